umbral_comparador: RTL and testbench

Upstream stage of the temperature-control state machine. Holds alarm and fan thresholds entered from the keypad, qualifies each temperature sample against them, and produces the registered activation levels `en`, `ac_alarma`, `ac_ventilador` and `lectura` that drive the controller's state transitions. Each activation requires N consecutive qualifying samples, and return-to-normal uses a hysteresis margin.

---
 rtl/umbral_comparador.sv | 178 +++++++++++++++++
 tb/tb_umbral_comparador.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/umbral_comparador.sv
// umbral_comparador
//   Threshold stage ahead of the temperature-control FSM. It stores the alarm
//   and fan thresholds entered from the keypad and checks their consistency.
//   Each valid temperature sample is qualified against the thresholds, and the
//   stage drives the registered activation levels for the controller.
//
//   Optional feature macro: COMP_FILTRO_EN
//     defined   : an activation needs N_CONF consecutive qualifying valid
//                 samples (saturating confirmation counters).
//     undefined : no counters are built. Each activation is the registered
//                 qualifier of the latest valid sample (N_CONF is ignored).
//
//   Parameters
//     W      : sample / threshold width (unsigned)
//     N_CONF : consecutive qualifying samples needed to activate (1..15)
//     HYST   : margin below the alarm threshold used for lectura
//
//   Ports
//     clk, rst       : clock, asynchronous active-high reset
//     umbral_dato    : threshold value from the keypad decoder
//     ld_alarma      : strobe, load umbral_dato into the alarm threshold
//     ld_ventilador  : strobe, load umbral_dato into the fan threshold
//     temp           : temperature sample
//     temp_valid     : strobe, temp holds a new sample
//     en             : both thresholds loaded and fan >= alarm
//     error          : both thresholds loaded and fan < alarm
//     ac_alarma      : temp >= alarm threshold (confirmed)
//     ac_ventilador  : temp >= fan threshold (confirmed)
//     lectura        : temp < alarm threshold - HYST (confirmed)
//     umbral_a/v     : current alarm / fan thresholds
module umbral_comparador #(
    parameter int W      = 8,
    parameter int N_CONF = 3,
    parameter int HYST   = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] umbral_dato,
    input  logic         ld_alarma,
    input  logic         ld_ventilador,
    input  logic [W-1:0] temp,
    input  logic         temp_valid,
    output logic         en,
    output logic         ac_alarma,
    output logic         ac_ventilador,
    output logic         lectura,
    output logic         error,
    output logic [W-1:0] umbral_a,
    output logic [W-1:0] umbral_v
);

    // Activation channels: alarm, fan, return-to-normal.
    localparam int CH_A = 0;
    localparam int CH_V = 1;
    localparam int CH_L = 2;
    localparam int NCH  = 3;

    if (N_CONF < 1 || N_CONF > 15) begin : g_nconf_fuera_rango
        $error("umbral_comparador: N_CONF must be in 1..15");
    end

    // ------------------------------------------------------------------
    // Threshold registers and consistency flags
    // ------------------------------------------------------------------
    logic [W-1:0] r_umbral_a, r_umbral_v;
    logic         r_carg_a, r_carg_v;
    logic         r_en, r_error;

    logic         w_load;
    logic [W-1:0] w_umbral_a_nxt, w_umbral_v_nxt;
    logic         w_carg_a_nxt, w_carg_v_nxt;
    logic         w_error_nxt, w_en_nxt;

    assign w_load         = ld_alarma | ld_ventilador;
    assign w_umbral_a_nxt = ld_alarma     ? umbral_dato : r_umbral_a;
    assign w_umbral_v_nxt = ld_ventilador ? umbral_dato : r_umbral_v;
    assign w_carg_a_nxt   = r_carg_a | ld_alarma;
    assign w_carg_v_nxt   = r_carg_v | ld_ventilador;

    // Computed from the post-load values so en/error settle on the same edge
    // that writes the threshold.
    assign w_error_nxt = w_carg_a_nxt & w_carg_v_nxt & (w_umbral_v_nxt < w_umbral_a_nxt);
    assign w_en_nxt    = w_carg_a_nxt & w_carg_v_nxt & ~w_error_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_umbral_a <= '0;
            r_umbral_v <= '0;
            r_carg_a   <= 1'b0;
            r_carg_v   <= 1'b0;
            r_error    <= 1'b0;
            r_en       <= 1'b0;
        end else begin
            r_umbral_a <= w_umbral_a_nxt;
            r_umbral_v <= w_umbral_v_nxt;
            r_carg_a   <= w_carg_a_nxt;
            r_carg_v   <= w_carg_v_nxt;
            r_error    <= w_error_nxt;
            r_en       <= w_en_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Sample qualifiers
    // ------------------------------------------------------------------
    // One extra bit catches underflow when umbral_a < HYST. The limit then
    // clamps to 0, and temp < 0 can never hold, so lectura stays low.
    logic [W:0]     w_lim_ext;
    logic [W-1:0]   w_lim_l;
    logic [NCH-1:0] w_qual;

    assign w_lim_ext = {1'b0, r_umbral_a} - (W+1)'(HYST);
    assign w_lim_l   = w_lim_ext[W] ? '0 : w_lim_ext[W-1:0];

    assign w_qual[CH_A] = (temp >= r_umbral_a);
    assign w_qual[CH_V] = (temp >= r_umbral_v);
    assign w_qual[CH_L] = (temp <  w_lim_l);

    // A load discards a coincident sample. While disabled, everything is
    // held cleared.
    logic w_clr, w_upd;
    assign w_clr = w_load | ~r_en;
    assign w_upd = temp_valid;

    logic [NCH-1:0] r_act;

`ifdef COMP_FILTRO_EN
    localparam int             CW      = $clog2(N_CONF + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(N_CONF);

    logic [NCH-1:0][CW-1:0] r_cnt, w_cnt_nxt;

    // Saturating run-length of consecutive qualifying valid samples.
    always_comb begin
        w_cnt_nxt = r_cnt;
        for (int i = 0; i < NCH; i++) begin
            if (!w_qual[i])
                w_cnt_nxt[i] = '0;
            else if (r_cnt[i] != CNT_MAX)
                w_cnt_nxt[i] = r_cnt[i] + 1'b1;
        end
    end

    // Activation is registered with the count it depends on, so it rises on
    // the edge that captures the N_CONF-th qualifying sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_act <= '0;
        end else if (w_clr) begin
            r_cnt <= '0;
            r_act <= '0;
        end else if (w_upd) begin
            r_cnt <= w_cnt_nxt;
            for (int i = 0; i < NCH; i++)
                r_act[i] <= (w_cnt_nxt[i] == CNT_MAX);
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_act <= '0;
        else if (w_clr)
            r_act <= '0;
        else if (w_upd)
            r_act <= w_qual;
    end
`endif

    assign en            = r_en;
    assign error         = r_error;
    assign umbral_a      = r_umbral_a;
    assign umbral_v      = r_umbral_v;
    assign ac_alarma     = r_act[CH_A];
    assign ac_ventilador = r_act[CH_V];
    assign lectura       = r_act[CH_L];

endmodule

// File: tb/tb_umbral_comparador.sv
// Self-checking bench for umbral_comparador: a table of directed vectors,
// hand-written reset sequences, then randomized traffic against a
// sample-history reference model.
module tb_umbral_comparador;

    localparam int W      = 8;
    localparam int N_CONF = 3;
    localparam int HYST   = 2;
`ifdef COMP_FILTRO_EN
    localparam int F = N_CONF;
`else
    localparam int F = 1;
`endif
    // Activation expected after the 1st / 2nd consecutive qualifying sample.
    localparam int Q1 = (F <= 1) ? 1 : 0;
    localparam int Q2 = (F <= 2) ? 1 : 0;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] umbral_dato;
    logic         ld_alarma, ld_ventilador;
    logic [W-1:0] temp;
    logic         temp_valid;
    logic         en, ac_alarma, ac_ventilador, lectura, error;
    logic [W-1:0] umbral_a, umbral_v;

    always #5 clk = ~clk;

    umbral_comparador #(.W(W), .N_CONF(N_CONF), .HYST(HYST)) dut (
        .clk(clk), .rst(rst),
        .umbral_dato(umbral_dato), .ld_alarma(ld_alarma), .ld_ventilador(ld_ventilador),
        .temp(temp), .temp_valid(temp_valid),
        .en(en), .ac_alarma(ac_alarma), .ac_ventilador(ac_ventilador),
        .lectura(lectura), .error(error),
        .umbral_a(umbral_a), .umbral_v(umbral_v)
    );

    int checks   = 0;
    int failures = 0;

    // ---------------- reference model ----------------
    // Keeps the valid samples seen since the last load; an output is active
    // when the last F of them all satisfy its rule.
    int m_ua, m_uv;
    bit m_ca, m_cv, m_en, m_err;
    int hist[$];

    task automatic model_reset();
        m_ua = 0; m_uv = 0; m_ca = 0; m_cv = 0; m_en = 0; m_err = 0;
        hist.delete();
    endtask

    function automatic int run_ok(int kind);
        if (hist.size() < F) return 0;
        for (int i = hist.size() - F; i < hist.size(); i++) begin
            case (kind)
                0: if (!(hist[i] >= m_ua)) return 0;
                1: if (!(hist[i] >= m_uv)) return 0;
                default: if (!(hist[i] < m_ua - HYST)) return 0;
            endcase
        end
        return 1;
    endfunction

    task automatic model_edge(int la, int lv, int dato, int tv, int t);
        if (la != 0 || lv != 0) begin
            if (la != 0) begin m_ua = dato; m_ca = 1; end
            if (lv != 0) begin m_uv = dato; m_cv = 1; end
            hist.delete();
            m_err = m_ca && m_cv && (m_uv < m_ua);
            m_en  = m_ca && m_cv && !m_err;
        end else if (tv != 0 && m_en) begin
            hist.push_back(t);
            if (hist.size() > 16) void'(hist.pop_front());
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model(string name);
        logic [4+2*W:0] a, e;
        a = {en, error, ac_alarma, ac_ventilador, lectura, umbral_a, umbral_v};
        e = {m_en, m_err, 1'(run_ok(0)), 1'(run_ok(1)), 1'(run_ok(2)), W'(m_ua), W'(m_uv)};
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got {en,err,aa,av,l,ua,uv}=%h expected %h at %0t", name, a, e, $time);
        end
    endtask

    // One clock: drive inputs, advance model on the edge, compare #1 after.
    task automatic step(int la, int lv, int dato, int tv, int t, string name);
        ld_alarma     = la[0];
        ld_ventilador = lv[0];
        umbral_dato   = W'(dato);
        temp_valid    = tv[0];
        temp          = W'(t);
        @(posedge clk);
        model_edge(la, lv, dato, tv, t);
        #1;
        ld_alarma = 0; ld_ventilador = 0; temp_valid = 0;
        compare_model(name);
    endtask

    typedef struct {
        int la, lv, dato, tv, t;
        int en, err, aa, av, l, ua, uv;
    } vec_t;

    vec_t tbl[28];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          la lv dato tv  t   en err aa  av  l   ua  uv
        tbl[0]  = '{1, 0, 30, 0,  0,  0, 0,  0,  0,  0,  30, 0 };
        tbl[1]  = '{0, 1, 40, 0,  0,  1, 0,  0,  0,  0,  30, 40};
        tbl[2]  = '{0, 0, 0,  1,  31, 1, 0,  Q1, 0,  0,  30, 40};
        tbl[3]  = '{0, 0, 0,  1,  31, 1, 0,  Q2, 0,  0,  30, 40};
        tbl[4]  = '{0, 0, 0,  1,  31, 1, 0,  1,  0,  0,  30, 40};
        tbl[5]  = '{0, 0, 0,  1,  29, 1, 0,  0,  0,  0,  30, 40};
        tbl[6]  = '{0, 0, 0,  1,  45, 1, 0,  Q1, Q1, 0,  30, 40};
        tbl[7]  = '{0, 0, 0,  1,  45, 1, 0,  Q2, Q2, 0,  30, 40};
        tbl[8]  = '{0, 0, 0,  1,  45, 1, 0,  1,  1,  0,  30, 40};
        tbl[9]  = '{0, 0, 0,  1,  27, 1, 0,  0,  0,  Q1, 30, 40};
        tbl[10] = '{0, 0, 0,  1,  27, 1, 0,  0,  0,  Q2, 30, 40};
        tbl[11] = '{0, 0, 0,  1,  27, 1, 0,  0,  0,  1,  30, 40};
        tbl[12] = '{0, 0, 0,  1,  31, 1, 0,  Q1, 0,  0,  30, 40};
        tbl[13] = '{0, 0, 0,  0,  0,  1, 0,  Q1, 0,  0,  30, 40};
        tbl[14] = '{0, 0, 0,  1,  25, 1, 0,  0,  0,  Q1, 30, 40};
        tbl[15] = '{0, 0, 0,  0,  0,  1, 0,  0,  0,  Q1, 30, 40};
        tbl[16] = '{0, 0, 0,  1,  31, 1, 0,  Q1, 0,  0,  30, 40};
        tbl[17] = '{0, 0, 0,  0,  0,  1, 0,  Q1, 0,  0,  30, 40};
        tbl[18] = '{0, 0, 0,  1,  31, 1, 0,  Q2, 0,  0,  30, 40};
        tbl[19] = '{0, 1, 20, 0,  0,  0, 1,  0,  0,  0,  30, 20};
        tbl[20] = '{0, 0, 0,  1,  50, 0, 1,  0,  0,  0,  30, 20};
        tbl[21] = '{0, 0, 0,  1,  50, 0, 1,  0,  0,  0,  30, 20};
        tbl[22] = '{0, 1, 40, 0,  0,  1, 0,  0,  0,  0,  30, 40};
        tbl[23] = '{1, 1, 35, 1,  50, 1, 0,  0,  0,  0,  35, 35};
        tbl[24] = '{1, 0, 30, 1,  50, 1, 0,  0,  0,  0,  30, 35};
        tbl[25] = '{0, 0, 0,  1,  50, 1, 0,  Q1, Q1, 0,  30, 35};
        tbl[26] = '{1, 0, 1,  0,  0,  1, 0,  0,  0,  0,  1,  35};
        tbl[27] = '{0, 0, 0,  1,  0,  1, 0,  0,  0,  0,  1,  35};

        // ---- reset state ----
        rst = 1; ld_alarma = 0; ld_ventilador = 0; umbral_dato = 0;
        temp = 0; temp_valid = 0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        check("rst_en", int'(en), 0);
        check("rst_error", int'(error), 0);
        check("rst_ac_alarma", int'(ac_alarma), 0);
        check("rst_ac_ventilador", int'(ac_ventilador), 0);
        check("rst_lectura", int'(lectura), 0);
        check("rst_umbral_a", int'(umbral_a), 0);
        check("rst_umbral_v", int'(umbral_v), 0);
        @(negedge clk); rst = 0;

        // ---- directed table ----
        for (int i = 0; i < 28; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            step(tbl[i].la, tbl[i].lv, tbl[i].dato, tbl[i].tv, tbl[i].t, nm);
            check({nm, "_en"},  int'(en),            tbl[i].en);
            check({nm, "_err"}, int'(error),         tbl[i].err);
            check({nm, "_aa"},  int'(ac_alarma),     tbl[i].aa);
            check({nm, "_av"},  int'(ac_ventilador), tbl[i].av);
            check({nm, "_l"},   int'(lectura),       tbl[i].l);
            check({nm, "_ua"},  int'(umbral_a),      tbl[i].ua);
            check({nm, "_uv"},  int'(umbral_v),      tbl[i].uv);
        end

        // ---- async reset while active ----
        step(1, 0, 30, 0, 0, "ar_load");
        for (int i = 0; i < F; i++) step(0, 0, 0, 1, 50, "ar_fill");
        check("ar_pre_ac_alarma", int'(ac_alarma), 1);
        check("ar_pre_ac_ventilador", int'(ac_ventilador), 1);
        @(negedge clk);
        rst = 1;
        #1;
        check("ar_async_ac_alarma", int'(ac_alarma), 0);
        check("ar_async_ac_ventilador", int'(ac_ventilador), 0);
        check("ar_async_en", int'(en), 0);
        check("ar_async_umbral_a", int'(umbral_a), 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        step(0, 0, 0, 1, 50, "ar_post_sample");
        check("ar_post_en", int'(en), 0);
        check("ar_post_ac_alarma", int'(ac_alarma), 0);
        step(1, 0, 30, 0, 0, "ar_reload_a");
        check("ar_reload_a_en", int'(en), 0);
        step(0, 1, 40, 0, 0, "ar_reload_v");
        check("ar_reload_v_en", int'(en), 1);

        // ---- randomized traffic ----
        for (int i = 0; i < 3000; i++) begin
            int la, lv, dato, tv, t;
            la   = ($urandom_range(0, 24) == 0) ? 1 : 0;
            lv   = ($urandom_range(0, 24) == 0) ? 1 : 0;
            dato = $urandom_range(0, 70);
            tv   = ($urandom_range(0, 9) < 7) ? 1 : 0;
            t    = $urandom_range(0, 80);
            step(la, lv, dato, tv, t, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
